// File: rtl/pipeline_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_stall_ctrl_pkg
// Shared definitions for the 5-stage core (IF, ID, EX, MEM, WB):
//   - stage index constants used to address per-stage vectors
//   - state encoding of the exception-flush controller
//   - reset PC used by the fetch stage
// No ports (package).
// ----------------------------------------------------------------------------
package pipeline_stall_ctrl_pkg;

  localparam int NUM_STAGES = 5;
  localparam int STG_IF     = 0;
  localparam int STG_ID     = 1;
  localparam int STG_EX     = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;

  // Boot vector loaded by fetch out of reset.
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BUS = 2'd1,
    ST_FLUSH    = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Generic saturating up-counter for performance monitoring.
// Ports:
//   clk   in          clock
//   rst   in          synchronous active-high reset (clears count)
//   inc   in          increment request for this cycle
//   clr   in          synchronous clear, wins over a same-cycle increment
//   count out CNT_W   current count, sticks at all-ones
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_stall_ctrl
// Central stall/flush controller for the 5-stage core.
// Ports:
//   clk            in            core clock
//   rst            in            synchronous reset, active-high
//   stall_req_if   in            IF waiting on instruction fetch
//   stall_req_id   in            ID load-use hazard
//   stall_req_ex   in            EX multicycle op busy
//   stall_req_mem  in            MEM waiting on data bus
//   exc_req        in            exception/eret accepted in MEM
//   exc_target     in  ADDR_W    handler/EPC address, valid with exc_req
//   cnt_clr        in            synchronous clear of stall counter
//   stall          out 5         per-stage stall, [0]=IF .. [4]=WB
//   flush          out           clear all pipeline registers this cycle
//   redirect_valid out           fetch must load redirect_pc
//   redirect_pc    out ADDR_W    redirect address (holds outside FLUSH)
//   stall_cycles   out CNT_W     saturating count of cycles with stall[0]=1
// ----------------------------------------------------------------------------
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req_if,
  input  logic                  stall_req_id,
  input  logic                  stall_req_ex,
  input  logic                  stall_req_mem,
  input  logic                  exc_req,
  input  logic [ADDR_W-1:0]     exc_target,
  input  logic                  cnt_clr,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_W-1:0]     redirect_pc,
  output logic [CNT_W-1:0]      stall_cycles
);

  // While waiting for the bus everything up to MEM is frozen; WB drains.
  localparam logic [NUM_STAGES-1:0] STALL_WAIT_BUS = {1'b0, {(NUM_STAGES-1){1'b1}}};

  ctrl_state_e r_state;
  ctrl_state_e w_state_next;

  logic [ADDR_W-1:0]     r_target;
  logic [ADDR_W-1:0]     w_target_next;
  logic [ADDR_W-1:0]     r_redirect_pc;
  logic [ADDR_W-1:0]     w_redirect_pc_next;
  logic [NUM_STAGES-2:0] w_req;
  logic [NUM_STAGES-1:0] w_stall_idle;
  logic [NUM_STAGES-1:0] w_stall;
  logic                  w_flush;

  assign w_req = {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if};

  // A request from stage k freezes stages 0..k, so stage i stalls when any
  // request at index >= i is present. The bubble lands in the register
  // after the highest stalled stage. WB never stalls.
  generate
    for (genvar gi = 0; gi < NUM_STAGES - 1; gi++) begin : g_stall_idle
      assign w_stall_idle[gi] = |w_req[NUM_STAGES-2:gi];
    end
  endgenerate
  assign w_stall_idle[STG_WB] = 1'b0;

  always_comb begin
    w_state_next       = r_state;
    w_target_next      = r_target;
    w_redirect_pc_next = r_redirect_pc;
    w_stall            = '0;
    w_flush            = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_stall = w_stall_idle;
        if (exc_req) begin
          w_target_next = exc_target;
          if (stall_req_mem) begin
            w_state_next = ST_WAIT_BUS;
          end else begin
            w_state_next       = ST_FLUSH;
            w_redirect_pc_next = exc_target;
          end
        end
      end

      ST_WAIT_BUS: begin
        // Later exceptions are dropped: the first one owns the target.
        w_stall = STALL_WAIT_BUS;
        if (!stall_req_mem) begin
          w_state_next       = ST_FLUSH;
          w_redirect_pc_next = r_target;
        end
      end

      ST_FLUSH: begin
        w_flush      = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_target      <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_state_next;
      r_target      <= w_target_next;
      r_redirect_pc <= w_redirect_pc_next;
    end
  end

  // Stall is combinational from the requests, so hold it low during reset.
  assign stall          = rst ? '0 : w_stall;
  assign flush          = w_flush;
  assign redirect_valid = w_flush;
  // Loaded on the edge entering FLUSH so it does not move while waiting.
  assign redirect_pc    = r_redirect_pc;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall[STG_IF]),
    .clr   (cnt_clr),
    .count (stall_cycles)
  );

endmodule
